// File: rtl/rx_riffa_axi.sv
// AXI4-Stream to RIFFA TX converter: one metadata word followed by packet data per transaction.
// Optional `RX_RIFFA_TSTAMP_EN: timestamp from an internal free-running cycle counter.
module rx_riffa_axi #(
    parameter int          C_PCI_DATA_WIDTH = 128,
    parameter logic [15:0] C_PREAM_VALUE    = 16'hCAFE
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [C_PCI_DATA_WIDTH-1:0] tdata,
    input  logic [15:0]                 tkeep,
    input  logic [127:0]                tuser,
    input  logic                        tvalid,
    input  logic                        tlast,
    output logic                        tready,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN,
    output logic                        err_short,
    output logic                        err_long
);

    typedef enum logic [2:0] {StIdle, StReq, StMeta, StData, StPad, StDrop} state_e;

    state_e                      state_q, state_d;
    logic [12:0]                 nwords_q, nwords_d;
    logic [12:0]                 sent_q, sent_d;
    logic [31:0]                 len_q, len_d;
    logic [127:0]                meta_q, meta_d;
    logic                        err_short_q, err_short_d;
    logic                        err_long_q, err_long_d;
    logic [63:0]                 tstamp;
    logic [16:0]                 len_round;
    logic [12:0]                 nwords_calc;
    logic [12:0]                 nwords_inc;
    logic                        last_word;
    logic                        tready_c, tx_c, valid_c;
    logic [C_PCI_DATA_WIDTH-1:0] data_c;

`ifdef RX_RIFFA_TSTAMP_EN
    logic [63:0] tstamp_q;
    logic        unused_bits;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + 64'd1;
        end
    end

    assign tstamp      = tstamp_q;
    assign unused_bits = ^{tkeep, tuser[127:32]};
`else
    logic unused_bits;

    assign tstamp      = tuser[127:64];
    assign unused_bits = ^{tkeep, tuser[63:32]};
`endif

    // Zero-length packets still carry one data word.
    assign len_round   = {1'b0, tuser[15:0]} + 17'd15;
    assign nwords_calc = (tuser[15:0] == 16'd0) ? 13'd1 : len_round[16:4];
    assign nwords_inc  = nwords_calc + 13'd1;
    assign last_word   = (sent_q == nwords_q - 13'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            nwords_q    <= '0;
            sent_q      <= '0;
            len_q       <= '0;
            meta_q      <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nwords_q    <= nwords_d;
            sent_q      <= sent_d;
            len_q       <= len_d;
            meta_q      <= meta_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nwords_d    = nwords_q;
        sent_d      = sent_q;
        len_d       = len_q;
        meta_d      = meta_q;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;
        tready_c    = 1'b0;
        tx_c        = 1'b0;
        valid_c     = 1'b0;
        data_c      = '0;

        unique case (state_q)
            StIdle: begin
                // Only tuser is captured here; the beat itself stays on the bus until DATA.
                if (tvalid) begin
                    nwords_d = nwords_calc;
                    len_d    = {17'd0, nwords_inc, 2'b00};
                    meta_d   = {tstamp, C_PREAM_VALUE, tuser[15:0], 8'h00, tuser[31:24],
                                8'h00, tuser[23:16]};
                    state_d  = StReq;
                end
            end
            StReq: begin
                tx_c = 1'b1;
                if (CHNL_TX_ACK) begin
                    state_d = StMeta;
                end
            end
            StMeta: begin
                tx_c    = 1'b1;
                valid_c = 1'b1;
                data_c  = meta_q;
                if (CHNL_TX_DATA_REN) begin
                    sent_d  = '0;
                    state_d = StData;
                end
            end
            StData: begin
                tx_c     = 1'b1;
                valid_c  = tvalid;
                data_c   = tvalid ? tdata : '0;
                tready_c = CHNL_TX_DATA_REN;
                if (tvalid && CHNL_TX_DATA_REN) begin
                    sent_d = sent_q + 13'd1;
                    if (last_word) begin
                        if (tlast) begin
                            state_d = StIdle;
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = StDrop;
                        end
                    end else if (tlast) begin
                        err_short_d = 1'b1;
                        state_d     = StPad;
                    end
                end
            end
            StPad: begin
                tx_c    = 1'b1;
                valid_c = 1'b1;
                if (CHNL_TX_DATA_REN) begin
                    sent_d = sent_q + 13'd1;
                    if (last_word) begin
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                tready_c = 1'b1;
                if (tvalid && tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign tready             = tready_c;
    assign CHNL_TX            = tx_c;
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_LEN        = len_q;
    assign CHNL_TX_OFF        = '0;
    assign CHNL_TX_DATA       = data_c;
    assign CHNL_TX_DATA_VALID = valid_c;
    assign err_short          = err_short_q;
    assign err_long           = err_long_q;

endmodule

// File: tb/tb_rx_riffa_axi.sv
// Randomized bench for rx_riffa_axi: expected RIFFA transactions are built per packet from
// the declared length, the beats actually sent and the metadata layout.
module tb_rx_riffa_axi;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tlast;
    logic         tready;
    logic         CHNL_TX;
    logic         CHNL_TX_ACK;
    logic         CHNL_TX_LAST;
    logic [31:0]  CHNL_TX_LEN;
    logic [30:0]  CHNL_TX_OFF;
    logic [127:0] CHNL_TX_DATA;
    logic         CHNL_TX_DATA_VALID;
    logic         CHNL_TX_DATA_REN;
    logic         err_short;
    logic         err_long;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_short, exp_long;

    rx_riffa_axi dut (
        .CLK               (CLK),
        .RST               (RST),
        .tdata             (tdata),
        .tkeep             (tkeep),
        .tuser             (tuser),
        .tvalid            (tvalid),
        .tlast             (tlast),
        .tready            (tready),
        .CHNL_TX           (CHNL_TX),
        .CHNL_TX_ACK       (CHNL_TX_ACK),
        .CHNL_TX_LAST      (CHNL_TX_LAST),
        .CHNL_TX_LEN       (CHNL_TX_LEN),
        .CHNL_TX_OFF       (CHNL_TX_OFF),
        .CHNL_TX_DATA      (CHNL_TX_DATA),
        .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
        .CHNL_TX_DATA_REN  (CHNL_TX_DATA_REN),
        .err_short         (err_short),
        .err_long          (err_long)
    );

    always #5 CLK = ~CLK;

`ifdef RX_RIFFA_TSTAMP_EN
    logic [63:0] ts_model;
    always @(posedge CLK or posedge RST) begin
        if (RST) ts_model <= '0;
        else     ts_model <= ts_model + 64'd1;
    end
`endif

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tvalid = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0; tkeep = '1;
        CHNL_TX_ACK = 1'b0; CHNL_TX_DATA_REN = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        exp_short = 1'b0;
        exp_long  = 1'b0;
    endtask

    task automatic run_pkt(input int len, input int nb, input logic [7:0] src,
                           input logic [7:0] dst, input logic [63:0] ts,
                           input int ren_mode, input bit gaps);
        logic [127:0] beats[$];
        logic [127:0] rx[$];
        logic [127:0] exp_w;
        logic [63:0]  meta_ts;
        logic [15:0]  len16;
        int nw, ndata, bi, c;
        bit presented, tx_prev, tx_done, ack_sent, ack_prev, fin;

        len16 = len[15:0];
        nw    = (len == 0) ? 1 : (len + 15) / 16;
        ndata = (nb < nw) ? nb : nw;
        for (int i = 0; i < nb; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        if (nb < nw) exp_short = 1'b1;
        if (nb > nw) exp_long  = 1'b1;
        meta_ts = ts;
        bi = 0; presented = 0; tx_prev = 0; tx_done = 0; ack_sent = 0; ack_prev = 0; fin = 0;

        for (c = 0; c < 400 && !fin; c++) begin
            @(negedge CLK);
            if (bi < nb && !presented)
                presented = (c == 0) || !gaps || ($urandom_range(0, 2) != 0);
            tvalid = presented;
            tdata  = presented ? beats[bi] : {$urandom, $urandom, $urandom, $urandom};
            tlast  = presented && (bi == nb - 1);
            tuser  = (bi == 0) ? {ts, 32'h0, dst, src, len16}
                               : {$urandom, $urandom, $urandom, $urandom};
            case (ren_mode)
                0:       CHNL_TX_DATA_REN = 1'b1;
                1:       CHNL_TX_DATA_REN = (c % 2 == 0);
                default: CHNL_TX_DATA_REN = ($urandom_range(0, 1) == 1);
            endcase
            CHNL_TX_ACK = CHNL_TX && !ack_sent && ($urandom_range(0, 1) == 1);
            if (CHNL_TX_ACK) ack_sent = 1;
            #1;
`ifdef RX_RIFFA_TSTAMP_EN
            if (c == 0) meta_ts = ts_model;
`endif
            if (c == 1) check("tx_latency", CHNL_TX, 1);
            if (ack_prev) check("meta_latency", CHNL_TX_DATA_VALID, 1);
            ack_prev = CHNL_TX_ACK;
            if (CHNL_TX) check("tx_len", CHNL_TX_LEN, 4 * (nw + 1));
            if (!CHNL_TX_DATA_VALID) check("data_zero_when_invalid", CHNL_TX_DATA, 0);
            if (rx.size() == 0) check("tready_before_data", tready, 0);
            if (CHNL_TX && rx.size() >= 1 && rx.size() - 1 < ndata)
                check("tready_mirrors_ren", tready, CHNL_TX_DATA_REN);
            if (tx_done && bi < nb) begin
                check("drop_tx_low", CHNL_TX, 0);
                check("drop_tready", tready, 1);
            end
            if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) rx.push_back(CHNL_TX_DATA);
            if (tvalid && tready) begin
                bi++;
                presented = 0;
            end
            if (tx_prev && !CHNL_TX) tx_done = 1;
            tx_prev = CHNL_TX;
            if (tx_done && bi >= nb) fin = 1;
        end
        if (!fin) check("pkt_timeout", 0, 1);

        check("word_count", rx.size(), nw + 1);
        for (int i = 0; i < rx.size() && i <= nw; i++) begin
            if (i == 0)          exp_w = {meta_ts, 16'hCAFE, len16, 8'h00, dst, 8'h00, src};
            else if (i - 1 < nb) exp_w = beats[i-1];
            else                 exp_w = '0;
            check(i == 0 ? "meta_word" : "data_word", rx[i], exp_w);
        end
        check("err_short", err_short, exp_short);
        check("err_long", err_long, exp_long);

        @(negedge CLK);
        tvalid = 1'b0; tlast = 1'b0; CHNL_TX_ACK = 1'b0;
    endtask

    task automatic reset_mid_packet();
        @(negedge CLK);
        tvalid = 1'b1; tlast = 1'b0; tuser = {64'h1, 48'h0, 16'd48};
        CHNL_TX_DATA_REN = 1'b1; CHNL_TX_ACK = 1'b0;
        @(negedge CLK);
        #1;
        check("rst_pre_tx", CHNL_TX, 1);
        RST = 1'b1;
        #1;
        check("rst_drops_tx", CHNL_TX, 0);
        check("rst_valid", CHNL_TX_DATA_VALID, 0);
        check("rst_len", CHNL_TX_LEN, 0);
        tvalid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        exp_short = 1'b0;
        exp_long  = 1'b0;
        #1;
        check("rst_err_short", err_short, 0);
        check("rst_err_long", err_long, 0);
    endtask

    initial begin
        int len, nw, nb;
        do_reset();
        RST = 1'b1;
        #1;
        check("reset_tready", tready, 0);
        check("reset_tx", CHNL_TX, 0);
        check("reset_valid", CHNL_TX_DATA_VALID, 0);
        check("reset_len", CHNL_TX_LEN, 0);
        check("reset_data", CHNL_TX_DATA, 0);
        check("reset_last", CHNL_TX_LAST, 1);
        check("reset_off", CHNL_TX_OFF, 0);
        check("reset_err_short", err_short, 0);
        check("reset_err_long", err_long, 0);
        @(negedge CLK);
        RST = 1'b0;

        run_pkt(64, 4, 8'h01, 8'h02, 64'hDEADBEEF00000001, 0, 0);
        run_pkt(17, 2, 8'h03, 8'h04, 64'h0123456789ABCDEF, 1, 0);
        run_pkt(64, 2, 8'h05, 8'h06, 64'h1111, 0, 0);
        run_pkt(32, 4, 8'h07, 8'h08, 64'h2222, 0, 0);
        run_pkt(40, 3, 8'h09, 8'h0A, 64'h3333, 2, 1);
        run_pkt(0, 1, 8'h0B, 8'h0C, 64'h4444, 0, 0);
        reset_mid_packet();

        for (int k = 0; k < 30; k++) begin
            len = $urandom_range(0, 100);
            nw  = (len == 0) ? 1 : (len + 15) / 16;
            nb  = ($urandom_range(0, 9) < 7) ? nw : $urandom_range(1, nw + 2);
            run_pkt(len, nb, 8'($urandom), 8'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_riffa_axi.md
# rx_riffa_axi

Converts NetFPGA AXI4-Stream packets (128-bit `tdata`, 128-bit `tuser`) into RIFFA channel TX transactions (FPGA-to-host). Each packet becomes exactly one RIFFA transaction: one 128-bit metadata word carrying preamble `16'hCAFE`, timestamp, byte length and ports, followed by the packet data words. It sits between the datapath output queue for the host port and the RIFFA channel, and mirrors the host-to-FPGA converter that strips this same metadata format.

## Interface
Parameters:
- `C_PCI_DATA_WIDTH`, 128, RIFFA and AXIS data width; only 128 is supported.
- `C_PREAM_VALUE`, `16'hCAFE`, preamble written to metadata bits [63:48].

Ports:
- `CLK`  in  1  single clock for the whole block.
- `RST`  in  1  reset, asynchronous and active-high.
- `tdata`  in  128  AXIS slave data.
- `tkeep`  in  16  AXIS slave byte enables; ignored, because length is taken from `tuser[15:0]`.
- `tuser`  in  128  [15:0] length in bytes, [23:16] source port, [31:24] destination port, [127:64] timestamp. Sampled on the first beat only.
- `tvalid`  in  1  AXIS slave valid.
- `tlast`  in  1  AXIS slave last beat.
- `tready`  out  1  AXIS slave ready.
- `CHNL_TX`  out  1  RIFFA transaction request.
- `CHNL_TX_ACK`  in  1  RIFFA request acknowledge.
- `CHNL_TX_LAST`  out  1  constant 1.
- `CHNL_TX_LEN`  out  32  transaction length in 32-bit dwords.
- `CHNL_TX_OFF`  out  31  constant 0.
- `CHNL_TX_DATA`  out  128  RIFFA data.
- `CHNL_TX_DATA_VALID`  out  1  RIFFA data valid.
- `CHNL_TX_DATA_REN`  in  1  RIFFA data read enable; a word transfers when VALID && REN.
- `err_short`  out  1  sticky flag: the packet ended before its declared length.
- `err_long`  out  1  sticky flag: the packet ran past its declared length.

## Operation
- Data-word count: `nwords = ceil(len_B/16)`, 13 bits wide. If `len_B == 0`, `nwords = 1`.
- `CHNL_TX_LEN = 4*(nwords+1)`, zero-extended to 32 bits. It is registered and held stable while `CHNL_TX` is high.
- Metadata word:
  - [127:64] timestamp
  - [63:48] `C_PREAM_VALUE`
  - [47:32] `len_B`
  - [31:24] 0
  - [23:16] destination port
  - [15:8] 0
  - [7:0] source port
- State machine:
  - IDLE: `tready=0`. On `tvalid`, latch `tuser` (not the beat itself), compute `nwords` and `LEN`, go to REQ.
  - REQ: `CHNL_TX=1`. On `CHNL_TX_ACK`, go to META.
  - META: `CHNL_TX_DATA`=metadata, `VALID=1`, `tready=0`. On `REN`, go to DATA and clear `words_sent`.
  - DATA: pass-through. `CHNL_TX_DATA=tdata`, `VALID=tvalid`, `tready=REN`. Increment `words_sent` on each transfer.
    - If the transfer is the last word (`words_sent == nwords-1`): with `tlast`, go to IDLE. Without `tlast`, set `err_long` and go to DROP.
    - If `tlast` arrives before the last word: set `err_short` and go to PAD.
  - PAD: `CHNL_TX_DATA=0`, `VALID=1`, `tready=0`. Count transfers; after the last word, go to IDLE.
  - DROP: `CHNL_TX=0`, `tready=1`. Discard beats; on `tvalid && tlast`, go to IDLE.
- `CHNL_TX` is 1 in REQ, META, DATA and PAD. It falls in the cycle after the last word transfers.
- `CHNL_TX_DATA` is 0 whenever `VALID=0`.
- Error flags are sticky and cleared only by `RST`.

## Timing
- Reset values: state IDLE; `tready`, `CHNL_TX`, `CHNL_TX_DATA_VALID`, `err_short` and `err_long` are 0; `CHNL_TX_LEN` and `CHNL_TX_DATA` are 0; `CHNL_TX_LAST` is 1.
- Asserting `RST` mid-transaction drops `CHNL_TX` immediately and abandons the packet with no recovery.
- Latency: first `tvalid` → `CHNL_TX` high 1 cycle later. `ACK` → metadata valid in the next cycle.
- Throughput: 1 word per cycle in DATA when `tvalid` and `REN` are both held high.
- The first AXIS beat is not accepted until DATA; it stays on the bus throughout IDLE, REQ and META.
- `ACK` arriving in the same cycle `CHNL_TX` rises is accepted.
- IDLE is re-entered for at least 1 cycle between packets, so `CHNL_TX` is low for at least 1 cycle.

## Configuration
- `RX_RIFFA_TSTAMP_EN` defined: the timestamp comes from an internal 64-bit free-running cycle counter. The counter resets to 0 and is sampled in IDLE when a packet is latched.
- `RX_RIFFA_TSTAMP_EN` undefined: the timestamp is `tuser[127:64]` of the first beat, and no counter is instantiated.

## Test plan
- 64 B packet, 4 beats, `tuser[15:0]=64`, src=`8'h01`, dst=`8'h02`, `REN` always 1 → `LEN=20`; metadata [63:48]=CAFE, [47:32]=64, [23:16]=02, [7:0]=01; then 4 data words identical to the input beats; `CHNL_TX` falls after word 5.
- 17 B packet, 2 beats, with `REN` toggling 1/0 each cycle → `LEN=12`, 3 words delivered, none lost or duplicated, `tready` mirrors `REN` in DATA.
- `len_B=64` but `tlast` on beat 2 → `err_short=1`; words 3 and 4 sent as zeros; `LEN=20` honoured.
- `len_B=32` but 4 beats → 2 data words sent, `err_long=1`, `CHNL_TX` low while beats 3–4 are dropped; the next packet is processed normally.
- `len_B=0` → `LEN=8`, metadata plus 1 data word.
- Timestamp, with `RX_RIFFA_TSTAMP_EN` defined: metadata [127:64] equals the counter value at latch. With it undefined: metadata [127:64] equals `tuser[127:64]`, e.g. `64'hDEADBEEF00000001`.
